// File: rtl/privacy_sram_pkg.sv
// privacy_sram_pkg: shared geometry, counter width and FSM state encoding for
// the privacy_SRAM sequencing controller. The ZERO state is only present when
// PRIVACY_SRAM_ZEROIZE_EN is defined.
package privacy_sram_pkg;

   localparam int ROWS   = 64;
   localparam int DATA_W = 10;
   localparam int ADDR_W = 6;
   localparam int CNT_W  = 4;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_PRECHARGE = 3'd1;
   localparam logic [2:0] ST_ACCESS    = 3'd2;
   localparam logic [2:0] ST_SENSE     = 3'd3;
   localparam logic [2:0] ST_RECOVER   = 3'd4;
`ifdef PRIVACY_SRAM_ZEROIZE_EN
   localparam logic [2:0] ST_ZERO      = 3'd5;
`endif

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_PRECHARGE = ST_PRECHARGE,
      S_ACCESS    = ST_ACCESS,
      S_SENSE     = ST_SENSE,
      S_RECOVER   = ST_RECOVER
`ifdef PRIVACY_SRAM_ZEROIZE_EN
      ,
      S_ZERO      = ST_ZERO
`endif
   } state_t;

   // Phase counters count down from (cycles - 1) to zero.
   function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/privacy_sram_wl_dec.sv
// privacy_sram_wl_dec: registered 6-to-64 one-hot wordline decoder. The output
// is all-zero whenever the enable is low, so it can never be more than one-hot.
module privacy_sram_wl_dec
   import privacy_sram_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   output logic [ROWS-1:0]   wl
);

   logic [ROWS-1:0] wl_r;

   // Register the decoded wordline; cleared on reset or when disabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         wl_r <= {ROWS{1'b0}};
      end else if (en) begin
         wl_r <= {{(ROWS-1){1'b0}}, 1'b1} << addr;
      end else begin
         wl_r <= {ROWS{1'b0}};
      end
   end

   assign wl = wl_r;

endmodule

// File: rtl/privacy_sram_ctrl.sv
// privacy_sram_ctrl: precharge / wordline / sense sequencer for the 64x10
// privacy_SRAM macro. All macro pins and handshake outputs are registered and
// derived from the next state, so each pin is aligned with its FSM phase.
// Optional full-array clear is compiled in with PRIVACY_SRAM_ZEROIZE_EN.
module privacy_sram_ctrl
   import privacy_sram_pkg::*;
#(
   parameter int PRE_CYC = 2,
   parameter int WL_CYC  = 2
)
(
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   input  logic              zeroize_req,
   output logic              sram_preb,
   output logic              sram_read_en,
   output logic              sram_write_en,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout,
   output logic [ROWS-1:0]   sram_wl
);

   if (PRE_CYC < 1 || PRE_CYC > 15) begin : g_bad_pre_cyc
      $error("PRE_CYC must be in 1..15");
   end
   if (WL_CYC < 1 || WL_CYC > 15) begin : g_bad_wl_cyc
      $error("WL_CYC must be in 1..15");
   end

   localparam logic [CNT_W-1:0]  PRE_LD   = cnt_load(PRE_CYC);
   localparam logic [CNT_W-1:0]  WL_LD    = cnt_load(WL_CYC);
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic              we_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic              hs_s, rsp_s, we_s, wl_en_s;
   logic [ADDR_W-1:0] wl_addr_s;
   logic [DATA_W-1:0] wdata_s;
   logic              req_ready_r, rsp_valid_r, busy_r, preb_r, rd_en_r, wr_en_r;
   logic [DATA_W-1:0] rdata_r, din_r;

`ifdef PRIVACY_SRAM_ZEROIZE_EN
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
   logic              zero_r, zero_s;
   logic [ADDR_W-1:0] row_r, row_s;

   // During a sweep the access is a forced write of zero to the sweep row.
   always_comb begin
      if (zero_r) begin
         we_s      = 1'b1;
         wdata_s   = {DATA_W{1'b0}};
         wl_addr_s = row_r;
      end else begin
         we_s      = we_r;
         wdata_s   = wdata_r;
         wl_addr_s = addr_r;
      end
   end
`else
   logic unused_zeroize_s;
   assign unused_zeroize_s = zeroize_req;

   // Access parameters come straight from the latched request.
   always_comb begin
      we_s      = we_r;
      wdata_s   = wdata_r;
      wl_addr_s = addr_r;
   end
`endif

   // Next-state, phase counter and completion-pulse decode.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      hs_s    = 1'b0;
      rsp_s   = 1'b0;
`ifdef PRIVACY_SRAM_ZEROIZE_EN
      zero_s  = zero_r;
      row_s   = row_r;
`endif
      case (state_r)
         S_IDLE: begin
`ifdef PRIVACY_SRAM_ZEROIZE_EN
            if (zeroize_req && req_ready_r) begin
               state_s = S_ZERO;
               zero_s  = 1'b1;
               row_s   = {ADDR_W{1'b0}};
            end else if (req_valid && req_ready_r) begin
               hs_s    = 1'b1;
               state_s = S_PRECHARGE;
               cnt_s   = PRE_LD;
            end else begin
               state_s = S_IDLE;
            end
`else
            if (req_valid && req_ready_r) begin
               hs_s    = 1'b1;
               state_s = S_PRECHARGE;
               cnt_s   = PRE_LD;
            end else begin
               state_s = S_IDLE;
            end
`endif
         end
         S_PRECHARGE: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = S_ACCESS;
               cnt_s   = WL_LD;
            end else begin
               cnt_s   = cnt_r - 4'd1;
            end
         end
         S_ACCESS: begin
            if (cnt_r == CNT_ZERO) begin
               if (we_s) begin
                  state_s = S_RECOVER;
`ifdef PRIVACY_SRAM_ZEROIZE_EN
                  rsp_s   = !zero_r;
`else
                  rsp_s   = 1'b1;
`endif
               end else begin
                  state_s = S_SENSE;
               end
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         S_SENSE: begin
            state_s = S_RECOVER;
            rsp_s   = 1'b1;
         end
         S_RECOVER: begin
`ifdef PRIVACY_SRAM_ZEROIZE_EN
            if (zero_r) begin
               if (row_r == LAST_ROW) begin
                  state_s = S_IDLE;
                  zero_s  = 1'b0;
                  rsp_s   = 1'b1;
               end else begin
                  state_s = S_ZERO;
                  row_s   = row_r + 6'd1;
               end
            end else begin
               state_s = S_IDLE;
            end
`else
            state_s = S_IDLE;
`endif
         end
`ifdef PRIVACY_SRAM_ZEROIZE_EN
         S_ZERO: begin
            state_s = S_PRECHARGE;
            cnt_s   = PRE_LD;
         end
`endif
         default: begin
            state_s = S_IDLE;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // Wordline stays up through ACCESS and SENSE; RECOVER drops it first.
   always_comb begin
      if ((state_s == S_ACCESS) || (state_s == S_SENSE)) begin
         wl_en_s = 1'b1;
      end else begin
         wl_en_s = 1'b0;
      end
   end

   // State, request latch and registered pin/handshake outputs.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r     <= S_IDLE;
         cnt_r       <= CNT_ZERO;
         we_r        <= 1'b0;
         addr_r      <= {ADDR_W{1'b0}};
         wdata_r     <= {DATA_W{1'b0}};
         req_ready_r <= 1'b0;
         rsp_valid_r <= 1'b0;
         rdata_r     <= {DATA_W{1'b0}};
         busy_r      <= 1'b0;
         preb_r      <= 1'b1;
         rd_en_r     <= 1'b0;
         wr_en_r     <= 1'b0;
         din_r       <= {DATA_W{1'b0}};
`ifdef PRIVACY_SRAM_ZEROIZE_EN
         zero_r      <= 1'b0;
         row_r       <= {ADDR_W{1'b0}};
`endif
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         if (hs_s) begin
            we_r    <= req_we;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
         end
         if (state_r == S_SENSE) begin
            rdata_r <= sram_dout;
         end
         req_ready_r <= (state_s == S_IDLE);
         busy_r      <= (state_s != S_IDLE);
         rsp_valid_r <= rsp_s;
         preb_r      <= (state_s != S_PRECHARGE);
         rd_en_r     <= wl_en_s && !we_s;
         wr_en_r     <= (state_s == S_ACCESS) && we_s;
         din_r       <= ((state_s == S_ACCESS) && we_s) ? wdata_s : {DATA_W{1'b0}};
`ifdef PRIVACY_SRAM_ZEROIZE_EN
         zero_r      <= zero_s;
         row_r       <= row_s;
`endif
      end
   end

   privacy_sram_wl_dec u_wl_dec (
      .clk  (wb_clk_i),
      .rst  (wb_rst_i),
      .en   (wl_en_s),
      .addr (wl_addr_s),
      .wl   (sram_wl)
   );

   assign req_ready     = req_ready_r;
   assign rsp_valid     = rsp_valid_r;
   assign rsp_rdata     = rdata_r;
   assign busy          = busy_r;
   assign sram_preb     = preb_r;
   assign sram_read_en  = rd_en_r;
   assign sram_write_en = wr_en_r;
   assign sram_din      = din_r;

endmodule

// File: tb/tb_privacy_sram_ctrl.sv
// tb_privacy_sram_ctrl: three controller instances (PRE/WL = 2/2, 1/1, 15/15),
// each with a behavioural macro and a reference model that predicts every pin
// from the cycle offset since the last accepted request.
module tb_privacy_sram_ctrl;

   logic clk;
   int   checks   = 0;
   int   errors   = 0;
   int   done_cnt = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic int oh_idx(input logic [63:0] v);
      for (int i = 0; i < 64; i++) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   function automatic logic [9:0] init_word(input int cfg, input int row);
      return 10'(((row * 41) + (cfg * 97)) ^ 341);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int P     = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
      localparam int W     = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
      localparam int LAT_W = (g == 0) ? 5 : ((g == 1) ? 3 : 31);
      localparam int LAT_R = (g == 0) ? 6 : ((g == 1) ? 4 : 32);
      localparam int GAP_W = (g == 0) ? 6 : ((g == 1) ? 4 : 32);
      localparam int NRAND = (g == 2) ? 10 : 40;

      logic        rst, req_valid, req_ready, req_we, rsp_valid, busy, zeroize_req;
      logic        sram_preb, sram_read_en, sram_write_en;
      logic [5:0]  req_addr;
      logic [9:0]  req_wdata, rsp_rdata, sram_din, sram_dout;
      logic [63:0] sram_wl;

      logic [9:0]  mac_mem [64];
      logic        mem_init_r = 1'b0;

      logic [9:0]  ref_mem [64];
      int          edge_cnt  = 0;
      int          t_hs      = 0;
      int          hs_cnt    = 0;
      bit          active    = 1'b0;
      bit          in_rst    = 1'b1;
      bit          hs_we     = 1'b0;
      logic [5:0]  hs_addr   = 6'd0;
      logic [9:0]  hs_wdata  = 10'h0;
      logic [9:0]  hs_rdata  = 10'h0;
      logic [9:0]  rdata_hold = 10'h0;
      logic        exp_ready = 1'b0;
      logic [9:0]  exp_rdata = 10'h0;
      int          rsp_lbl   = 0;
      logic [9:0]  rsp_data  = 10'h0;

      privacy_sram_ctrl #(.PRE_CYC(P), .WL_CYC(W)) dut (
         .wb_clk_i      (clk),
         .wb_rst_i      (rst),
         .req_valid     (req_valid),
         .req_ready     (req_ready),
         .req_we        (req_we),
         .req_addr      (req_addr),
         .req_wdata     (req_wdata),
         .rsp_valid     (rsp_valid),
         .rsp_rdata     (rsp_rdata),
         .busy          (busy),
         .zeroize_req   (zeroize_req),
         .sram_preb     (sram_preb),
         .sram_read_en  (sram_read_en),
         .sram_write_en (sram_write_en),
         .sram_din      (sram_din),
         .sram_dout     (sram_dout),
         .sram_wl       (sram_wl)
      );

      // Behavioural macro: write on the clock, combinational read of the WL row.
      always @(posedge clk) begin
         if (!mem_init_r) begin
            for (int i = 0; i < 64; i++) mac_mem[i] <= init_word(g, i);
            mem_init_r <= 1'b1;
         end else if (sram_write_en && (sram_wl != 64'h0)) begin
            mac_mem[oh_idx(sram_wl)] <= sram_din;
         end
      end
      assign sram_dout = (sram_read_en && (sram_wl != 64'h0)) ? mac_mem[oh_idx(sram_wl)] : 10'h000;

      // Reference model: record reset and accepted requests at each edge.
      initial begin
         for (int i = 0; i < 64; i++) ref_mem[i] = init_word(g, i);
         forever begin
            @(posedge clk);
            edge_cnt++;
            in_rst = rst;
            if (rst) begin
               active     = 1'b0;
               rdata_hold = 10'h0;
            end else if (req_valid && exp_ready) begin
               rdata_hold = exp_rdata;
               t_hs       = edge_cnt;
               hs_we      = req_we;
               hs_addr    = req_addr;
               hs_wdata   = req_wdata;
               hs_rdata   = ref_mem[req_addr];
               if (req_we) ref_mem[req_addr] = req_wdata;
               active     = 1'b1;
               hs_cnt++;
            end
         end
      end

      // Compare every output each cycle against the phase implied by the offset.
      initial begin
         int          k, done_k;
         logic        e_ready, e_rsp, e_busy, e_preb, e_rd, e_wr;
         logic [9:0]  e_din, e_rdata;
         logic [63:0] e_wl;
         forever begin
            @(negedge clk);
            k       = edge_cnt + 1 - t_hs;
            e_ready = 1'b1; e_rsp = 1'b0; e_busy = 1'b0; e_preb = 1'b1;
            e_rd    = 1'b0; e_wr  = 1'b0; e_din  = 10'h0; e_wl   = 64'h0;
            e_rdata = rdata_hold;
            if (in_rst) begin
               e_ready = 1'b0;
               e_rdata = 10'h0;
            end else if (active) begin
               done_k = hs_we ? (P + W + 2) : (P + W + 3);
               if (k < done_k) begin
                  e_ready = 1'b0;
                  e_busy  = 1'b1;
               end
               if (k >= 1 && k <= P) begin
                  e_preb = 1'b0;
               end else if ((k > P) && ((k <= P + W) || (!hs_we && (k == P + W + 1)))) begin
                  e_wl  = 64'd1 << hs_addr;
                  e_rd  = !hs_we;
                  e_wr  = hs_we;
                  e_din = hs_we ? hs_wdata : 10'h0;
               end
               if (k == done_k - 1) e_rsp = 1'b1;
               if (!hs_we && (k >= done_k - 1)) e_rdata = hs_rdata;
            end
            exp_ready = e_ready;
            exp_rdata = e_rdata;
            if (edge_cnt > 0) begin
               chk($sformatf("c%0d_req_ready", g), {63'h0, req_ready}, {63'h0, e_ready});
               chk($sformatf("c%0d_rsp_valid", g), {63'h0, rsp_valid}, {63'h0, e_rsp});
               chk($sformatf("c%0d_rsp_rdata", g), {54'h0, rsp_rdata}, {54'h0, e_rdata});
               chk($sformatf("c%0d_busy", g), {63'h0, busy}, {63'h0, e_busy});
               chk($sformatf("c%0d_preb", g), {63'h0, sram_preb}, {63'h0, e_preb});
               chk($sformatf("c%0d_read_en", g), {63'h0, sram_read_en}, {63'h0, e_rd});
               chk($sformatf("c%0d_write_en", g), {63'h0, sram_write_en}, {63'h0, e_wr});
               chk($sformatf("c%0d_din", g), {54'h0, sram_din}, {54'h0, e_din});
               chk($sformatf("c%0d_wl", g), sram_wl, e_wl);
               chk($sformatf("c%0d_pin_invariants", g),
                   {63'h0, (($countones(sram_wl) <= 1) && !(sram_read_en && sram_write_en) &&
                            !((sram_wl != 64'h0) && !sram_preb) &&
                            !(sram_write_en && (sram_wl == 64'h0)))}, 64'h1);
               if (rsp_valid) begin
                  rsp_lbl  = edge_cnt + 1;
                  rsp_data = rsp_rdata;
               end
            end
         end
      end

      task automatic send(input logic we, input logic [5:0] a, input logic [9:0] d);
         int start;
         bit ok;
         start     = hs_cnt;
         ok        = 1'b0;
         req_valid = 1'b1;
         req_we    = we;
         req_addr  = a;
         req_wdata = d;
         for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = (hs_cnt != start);
         end
         chk($sformatf("c%0d_handshake_seen", g), {63'h0, ok}, 64'h1);
      endtask

      task automatic wait_idle();
         bit ok;
         ok = 1'b0;
         for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = exp_ready;
         end
         chk($sformatf("c%0d_idle_seen", g), {63'h0, ok}, 64'h1);
      endtask

      // Stimulus: directed pins of the model, then randomized traffic.
      initial begin
         int t1, t2;
         req_valid = 1'b0; req_we = 1'b0; req_addr = 6'd0; req_wdata = 10'h0;
         zeroize_req = 1'b0;
         rst = 1'b1;
         repeat (3) @(negedge clk);
         rst = 1'b0;
         @(negedge clk);

         send(1'b1, 6'd5, 10'h2A5);
         t1 = t_hs;
         req_valid = 1'b0;
         wait_idle();
         chk($sformatf("c%0d_write_latency", g), 64'(rsp_lbl - t1), 64'(LAT_W));

         send(1'b0, 6'd5, 10'h000);
         t1 = t_hs;
         req_valid = 1'b0;
         wait_idle();
         chk($sformatf("c%0d_read_latency", g), 64'(rsp_lbl - t1), 64'(LAT_R));
         chk($sformatf("c%0d_read_data", g), {54'h0, rsp_data}, 64'h2A5);

         send(1'b1, 6'd63, 10'h3C3);
         t1 = t_hs;
         send(1'b0, 6'd0, 10'h000);
         t2 = t_hs;
         req_valid = 1'b0;
         wait_idle();
         chk($sformatf("c%0d_b2b_spacing", g), 64'(t2 - t1), 64'(GAP_W));

         if (g == 0) begin
            send(1'b0, 6'd7, 10'h000);
            req_valid = 1'b0;
            repeat (2) @(negedge clk);
            chk("c0_mid_access_wl", sram_wl, 64'h80);
            rst = 1'b1;
            @(negedge clk);
            chk("c0_rst_wl", sram_wl, 64'h0);
            chk("c0_rst_read_en", {63'h0, sram_read_en}, 64'h0);
            chk("c0_rst_preb", {63'h0, sram_preb}, 64'h1);
            chk("c0_rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
            chk("c0_rst_ready", {63'h0, req_ready}, 64'h0);
            rst = 1'b0;
            @(negedge clk);
            chk("c0_ready_after_rst", {63'h0, req_ready}, 64'h1);
         end

         for (int n = 0; n < NRAND; n++) begin
            send(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 10'($urandom_range(0, 1023)));
            if ($urandom_range(0, 2) != 0) begin
               req_valid = 1'b0;
               repeat ($urandom_range(0, 3)) @(negedge clk);
            end
         end
         req_valid = 1'b0;
         wait_idle();
         done_cnt++;
      end
   end

   // Wait for all configurations, bounded, then report.
   initial begin
      bit fin;
      fin = 1'b0;
      for (int i = 0; i < 90000 && !fin; i++) begin
         @(negedge clk);
         #2;
         fin = (done_cnt == 3);
      end
      chk("all_configs_done", {63'h0, fin}, 64'h1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/privacy_sram_ctrl.md
Name: privacy_sram_ctrl

Overview:
Sequencing controller for the 64-row x 10-bit privacy_SRAM hard macro in the user project area. It accepts single-word read/write requests on a valid/ready interface and decodes the 6-bit address to a one-hot wordline. It drives the precharge/WL/enable phases with programmable cycle counts and returns read data on a one-cycle response pulse. It is the only block that toggles the macro pins.

Parameters:
PRE_CYC, 2, cycles PreB held low (bitline precharge); legal 1..15
WL_CYC, 2, cycles wordline + read_en/write_en asserted before sense/finish; legal 1..15
ROWS, 64, wordline count (fixed by macro; ADDR_W = 6)
DATA_W, 10, data width (fixed by macro)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_we  in  1  1 = write, 0 = read
req_addr  in  6  row index
req_wdata  in  10  write data
rsp_valid  out  1  one-cycle completion pulse (read and write)
rsp_rdata  out  10  read data, valid with rsp_valid on reads, held otherwise
busy  out  1  state != IDLE
zeroize_req  in  1  start full-array clear (used only with the optional feature)
sram_preb  out  1  macro PreB, active-low precharge
sram_read_en  out  1  macro read_en
sram_write_en  out  1  macro write_en
sram_din  out  10  macro DataIn9..0
sram_dout  in  10  macro DataOut9..0
sram_wl  out  64  macro WL63..0, one-hot or zero

Behaviour:
- Reset values: req_ready=0 during reset and 1 in the first cycle after it; rsp_valid=0; rsp_rdata=0; busy=0; sram_preb=1; sram_read_en=0; sram_write_en=0; sram_din=0; sram_wl=0.
- All outputs are registered. Handshake fires on the edge where req_valid && req_ready. The controller latches addr, we and wdata on that edge and ignores the inputs afterwards.
- FSM states: IDLE, PRECHARGE, ACCESS, SENSE, RECOVER, plus ZERO when the optional feature is compiled in.
- IDLE: everything is deasserted. On handshake, move to PRECHARGE.
- PRECHARGE: sram_preb=0 for PRE_CYC cycles, then move to ACCESS.
- ACCESS: sram_preb=1; sram_wl = 1 << addr; sram_read_en = !we; sram_write_en = we; sram_din = wdata (write only, else 0). Lasts WL_CYC cycles. Reads then go to SENSE; writes go to RECOVER and pulse rsp_valid on RECOVER entry.
- SENSE (reads only, 1 cycle): WL and read_en stay asserted. sram_dout is captured into rsp_rdata at the end of the cycle. Then move to RECOVER with rsp_valid=1.
- RECOVER (1 cycle): WL, enables and din are all 0 and preb=1 (break-before-make). Then move to IDLE.
- Latency with defaults, handshake at edge T: read has rsp_valid high during cycle T+6 (PRE T+1..T+2, ACC T+3..T+4, SENSE T+5). Write has rsp_valid at T+5. req_ready returns at T+7 (read) or T+6 (write).
- Invariants: sram_wl is never more than one-hot. read_en and write_en are never both 1. WL is never active while preb=0. write_en is never active without a WL.
- req_valid held with no ready produces no effect. Back-to-back requests therefore have a minimum spacing of PRE_CYC+WL_CYC+3 cycles (read) or +2 cycles (write).
- Reset mid-operation: on the next edge all macro pins return to their reset values and state returns to IDLE. No rsp_valid is produced and the in-flight write has undefined array effect.
- Counters are 4-bit down-counters loaded with PARAM-1. Parameter values outside 1..15 are rejected at elaboration.

Optional Feature:
PRIVACY_SRAM_ZEROIZE_EN
- Defined: zeroize_req sampled high in IDLE (priority over req_valid in the same cycle) starts a sweep. The sweep performs PRECHARGE/ACCESS(write, din=0)/RECOVER for rows 0..63 in order. busy=1 and req_ready=0 throughout. A single rsp_valid pulse is emitted after row 63's RECOVER, with rsp_rdata unchanged.
- Undefined: zeroize_req is ignored, the ZERO state and row counter are absent, and behaviour is identical to the base spec.

Decomposition:
- Package privacy_sram_pkg holds the state enum encoding (3-bit localparams), ROWS=64, DATA_W=10, ADDR_W=6 and the counter width of 4.
- One sub-module: privacy_sram_wl_dec, a registered 6-to-64 one-hot decoder with an enable input. Its output is zero when the enable is 0.

Test Plan:
- Reset then write addr 5, data 0x2A5 -> sram_wl=1<<5 with write_en=1 and din=0x2A5 for exactly 2 cycles after 2 preb-low cycles; rsp_valid at T+5; ready at T+6.
- Read addr 5, macro model returns 0x2A5 -> read_en with WL5 for 3 cycles; rsp_valid at T+6 with rsp_rdata=0x2A5.
- Write addr 63 then read addr 0 back-to-back with req_valid held -> second handshake at T+6; WL63 and WL0 never overlap; one zero-WL RECOVER cycle between them.
- Assert wb_rst_i during ACCESS of a read -> next edge: wl=0, enables=0, preb=1, no rsp_valid; ready=1 after release.
- Sweep PRE_CYC=1/WL_CYC=1 and PRE_CYC=15/WL_CYC=15 -> phase lengths match exactly; the one-hot assertion holds every cycle.
- With PRIVACY_SRAM_ZEROIZE_EN: zeroize_req and req_valid both high in IDLE -> 64 write cycles with din=0 on rows 0..63; single rsp_valid at the end; subsequent reads of any row return 0.
